// File: rtl/muller_c_sequencer.sv
// Four-phase sequencer driving an external Muller C-element and checking its hold/fire behaviour.
// Define MULLER_C_SEQ_LOOP_EN to chain cycles back-to-back while start_i stays high.
module muller_c_sequencer #(
  parameter int TIMEOUT_W   = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [1:0]           skew_i,
  input  logic [3:0]           gap_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 c_q_i,
  output logic                 c_a_o,
  output logic                 c_b_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     cycles_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE1   = 3'd1,
    RISE2   = 3'd2,
    WAIT_HI = 3'd3,
    FALL1   = 3'd4,
    FALL2   = 3'd5,
    WAIT_LO = 3'd6,
    ERROR   = 3'd7
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] q_sync_p;
  logic [1:0]             skew_q;
  logic [3:0]             gap_q;
  logic [3:0]             gap_cnt_q;
  logic [TIMEOUT_W-1:0]   wait_cnt_q;
  logic [TIMEOUT_W-1:0]   wait_nxt;
  logic                   qs;
  logic                   skewed;
  logic                   a_leads;
  logic                   gap_on;
  logic                   gap_last;
  logic                   timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Synchronizer stage boundary: c_q_i is asynchronous, only qs feeds the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_sync_p <= '0;
    else        q_sync_p <= {q_sync_p[SYNC_STAGES-2:0], c_q_i};
  end

  assign qs          = q_sync_p[SYNC_STAGES-1];
  assign skewed      = skew_q[0] ^ skew_q[1];
  assign a_leads     = skew_q[0];
  assign gap_on      = skewed && (gap_q != 4'd0);
  assign gap_last    = (gap_cnt_q == 4'd1);
  assign wait_nxt    = wait_cnt_q + 1'b1;
  assign timeout_hit = (timeout_i != '0) && (wait_nxt == timeout_i);
  assign state_o     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      c_a_o      <= 1'b0;
      c_b_o      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      cycles_o   <= '0;
      skew_q     <= 2'b00;
      gap_q      <= 4'd0;
      gap_cnt_q  <= 4'd0;
      wait_cnt_q <= '0;
    end else begin
      done_o <= 1'b0;
      if (stop_i) begin
        state_q <= IDLE;
        c_a_o   <= 1'b0;
        c_b_o   <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start_i) begin
            skew_q <= skew_i;
            gap_q  <= gap_i;
            if (qs) begin
              state_q <= ERROR;
              err_o   <= 1'b1;
              busy_o  <= 1'b0;
            end else begin
              state_q <= RISE1;
              busy_o  <= 1'b1;
            end
          end
          RISE1: begin
            gap_cnt_q <= gap_q;
            if (gap_on) begin
              c_a_o   <= a_leads;
              c_b_o   <= ~a_leads;
              state_q <= RISE2;
            end else begin
              c_a_o      <= 1'b1;
              c_b_o      <= 1'b1;
              wait_cnt_q <= '0;
              state_q    <= WAIT_HI;
            end
          end
          // Only one input is high, so a firing output means the element did not hold
          RISE2: if (qs) begin
            state_q <= ERROR;
            c_a_o   <= 1'b0;
            c_b_o   <= 1'b0;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
            if (gap_last) begin
              c_a_o      <= 1'b1;
              c_b_o      <= 1'b1;
              wait_cnt_q <= '0;
              state_q    <= WAIT_HI;
            end
          end
          WAIT_HI: if (qs) begin
            state_q <= FALL1;
          end else if (timeout_hit) begin
            state_q <= ERROR;
            c_a_o   <= 1'b0;
            c_b_o   <= 1'b0;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            wait_cnt_q <= wait_nxt;
          end
          FALL1: begin
            gap_cnt_q <= gap_q;
            if (gap_on) begin
              c_a_o   <= ~a_leads;
              c_b_o   <= a_leads;
              state_q <= FALL2;
            end else begin
              c_a_o      <= 1'b0;
              c_b_o      <= 1'b0;
              wait_cnt_q <= '0;
              state_q    <= WAIT_LO;
            end
          end
          FALL2: if (!qs) begin
            state_q <= ERROR;
            c_a_o   <= 1'b0;
            c_b_o   <= 1'b0;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
            if (gap_last) begin
              c_a_o      <= 1'b0;
              c_b_o      <= 1'b0;
              wait_cnt_q <= '0;
              state_q    <= WAIT_LO;
            end
          end
          WAIT_LO: if (!qs) begin
            done_o   <= 1'b1;
            cycles_o <= sat_inc(cycles_o);
`ifdef MULLER_C_SEQ_LOOP_EN
            if (start_i) begin
              skew_q  <= skew_i;
              gap_q   <= gap_i;
              state_q <= RISE1;
            end else begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end
`else
            state_q <= IDLE;
            busy_o  <= 1'b0;
`endif
          end else if (timeout_hit) begin
            state_q <= ERROR;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            wait_cnt_q <= wait_nxt;
          end
          ERROR: if (start_i && !qs) begin
            skew_q  <= skew_i;
            gap_q   <= gap_i;
            err_o   <= 1'b0;
            busy_o  <= 1'b1;
            state_q <= RISE1;
          end
          default: begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muller_c_sequencer.sv
// Directed bench for muller_c_sequencer with a behavioural C-element model that can be made faulty.
module tb_muller_c_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [1:0] skew_i = 2'b00;
  logic [3:0] gap_i = 4'd0;
  logic [7:0] timeout_i = 8'd20;
  logic       c_q;
  logic       c_a, c_b, busy, done, err;
  logic [15:0] cycles;
  logic [2:0] state;
  logic       s_a, s_b, s_busy, s_done, s_err;
  logic [1:0] s_cycles;
  logic [2:0] s_state;

  int n_checks = 0;
  int n_errors = 0;
  int mode = 0;  // 0 C-element, 1 q=a|b, 2 stuck 0, 3 stuck 1

  // watch() results
  int w_timed_out, w_done, w_hi, w_lo, w_split, w_prev_state;
  int w_a_rise, w_b_rise, w_a_fall, w_b_fall;

  always #5 clk = ~clk;

  muller_c_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .skew_i(skew_i),
    .gap_i(gap_i), .timeout_i(timeout_i), .c_q_i(c_q), .c_a_o(c_a), .c_b_o(c_b),
    .busy_o(busy), .done_o(done), .err_o(err), .cycles_o(cycles), .state_o(state)
  );

  // Narrow-counter twin, same stimulus, to exercise saturation
  muller_c_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .skew_i(skew_i),
    .gap_i(gap_i), .timeout_i(timeout_i), .c_q_i(c_q), .c_a_o(s_a), .c_b_o(s_b),
    .busy_o(s_busy), .done_o(s_done), .err_o(s_err), .cycles_o(s_cycles), .state_o(s_state)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_q <= 1'b0;
    else case (mode)
      0: if (c_a && c_b) c_q <= 1'b1; else if (!c_a && !c_b) c_q <= 1'b0;
      1: c_q <= c_a | c_b;
      2: c_q <= 1'b0;
      default: c_q <= 1'b1;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic watch(input int max);
    logic pa, pb;
    pa = c_a; pb = c_b;
    w_timed_out = 1; w_done = 0; w_hi = 0; w_lo = 0; w_split = 0; w_prev_state = -1;
    w_a_rise = -1; w_b_rise = -1; w_a_fall = -1; w_b_fall = -1;
    for (int i = 0; i < max; i++) begin
      if (state == 3'd3) w_hi++;
      if (state == 3'd6) w_lo++;
      if (done) w_done++;
      if (c_a !== c_b) w_split = 1;
      if (c_a && !pa) w_a_rise = i;
      if (c_b && !pb) w_b_rise = i;
      if (!c_a && pa) w_a_fall = i;
      if (!c_b && pb) w_b_fall = i;
      pa = c_a; pb = c_b;
      if (i > 0 && (state == 3'd0 || state == 3'd7)) begin
        w_timed_out = 0;
        break;
      end
      w_prev_state = int'(state);
      @(negedge clk);
    end
  endtask

  initial begin
    int n, n_done, n_busy_low;
    repeat (2) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_ab", {c_a, c_b}, 0);
    chk("reset_busy_done_err", {busy, done, err}, 0);
    chk("reset_cycles", cycles, 0);
    do_reset();

    // 1: skew 00
    skew_i = 2'b00; gap_i = 4'd0; timeout_i = 8'd20;
    pulse_start();
    chk("t1_rise1", state, 1);
    chk("t1_busy", busy, 1);
    watch(100);
    chk("t1_finished", w_timed_out, 0);
    chk("t1_idle", state, 0);
    chk("t1_together", w_split, 0);
    chk("t1_wait_hi_len", w_hi, 4);
    chk("t1_wait_lo_len", w_lo, 4);
    chk("t1_done_pulses", w_done, 1);
    chk("t1_cycles", cycles, 1);
    chk("t1_err", err, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);

    // 2: a leads by 5, skew_i changed mid-cycle must be ignored
    do_reset();
    skew_i = 2'b01; gap_i = 4'd5;
    pulse_start();
    skew_i = 2'b00; gap_i = 4'd0;
    watch(200);
    chk("t2_finished", w_timed_out, 0);
    chk("t2_rise_gap", w_b_rise - w_a_rise, 5);
    chk("t2_fall_gap", w_b_fall - w_a_fall, 5);
    chk("t2_err", err, 0);
    chk("t2_cycles", cycles, 1);

    // 3: q=a|b, b leads, gap 4 -> hold violation in RISE2
    do_reset();
    mode = 1; skew_i = 2'b10; gap_i = 4'd4;
    pulse_start();
    watch(100);
    chk("t3_error_state", state, 7);
    chk("t3_from_rise2", w_prev_state, 2);
    chk("t3_a_never_rose", w_a_rise, -1);
    chk("t3_err", err, 1);
    chk("t3_ab_low", {c_a, c_b}, 0);
    chk("t3_cycles", cycles, 0);
    chk("t3_busy", busy, 0);
    // Recover from ERROR with a healthy element
    mode = 0;
    repeat (5) @(negedge clk);
    pulse_start();
    chk("t3_exit_state", state, 1);
    chk("t3_exit_err_clear", err, 0);
    watch(200);
    chk("t3_recover_cycles", cycles, 1);

    // Stale output at start, ERROR sticky, stop leaves err
    mode = 3;
    repeat (5) @(negedge clk);
    pulse_start();
    chk("stale_error", state, 7);
    chk("stale_err", err, 1);
    pulse_start();
    chk("stale_stays_error", state, 7);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("stop_from_error", state, 0);
    chk("stop_keeps_err", err, 1);

    // 4: q stuck 0, timeout 10
    do_reset();
    mode = 2; skew_i = 2'b00; gap_i = 4'd0; timeout_i = 8'd10;
    pulse_start();
    watch(100);
    chk("t4_error_state", state, 7);
    chk("t4_wait_hi_cycles", w_hi, 10);
    chk("t4_err", err, 1);
    // timeout disabled
    do_reset();
    mode = 2; timeout_i = 8'd0;
    pulse_start();
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (state == 3'd3) n++;
    end
    chk("t4_no_timeout", n, 1000);
    chk("t4_no_err", err, 0);

    // 5: stop during WAIT_HI
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("t5_stop_idle", state, 0);
    chk("t5_stop_ab", {c_a, c_b}, 0);
    chk("t5_stop_no_done", done, 0);
    chk("t5_stop_cycles", cycles, 0);
    chk("t5_stop_busy", busy, 0);
    // async reset mid-cycle
    do_reset();
    timeout_i = 8'd20;
    pulse_start();
    watch(100);
    pulse_start();
    @(negedge clk);
    chk("t5_mid_cycle_ab", {c_a, c_b}, 3);
    chk("t5_mid_cycle_count", cycles, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_state", state, 0);
    chk("t5_rst_ab", {c_a, c_b}, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cycles", cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 6: start held for four cycles
    skew_i = 2'b00; gap_i = 4'd0;
    start_i = 1'b1;
    @(negedge clk);
    n_done = 0; n_busy_low = 0;
    for (int i = 0; i < 600 && n_done < 4; i++) begin
      if (done) n_done++;
      if (n_done < 4 && !busy) n_busy_low++;
      if (n_done == 3 && state == 3'd6) start_i = 1'b0;
      if (n_done < 4) @(negedge clk);
    end
    start_i = 1'b0;
    chk("t6_done_count", n_done, 4);
    chk("t6_cycles", cycles, 4);
`ifdef MULLER_C_SEQ_LOOP_EN
    chk("t6_busy_low_between", n_busy_low, 0);
`else
    chk("t6_busy_low_between", n_busy_low, 3);
`endif
    chk("t6_sat_cycles", s_cycles, 3);
    @(negedge clk);
    chk("t6_back_idle", state, 0);
    pulse_start();
    watch(100);
    chk("t6_cycles_5", cycles, 5);
    chk("t6_sat_holds", s_cycles, 3);
    chk("t6_twin_state", s_state, state);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
